traffic_phase_sequencer: RTL and testbench

// Sequences the intersection's lights from the lane set picked by DayTime (laneOutput, NNEESSWW) and the
// 2-bit mode from TrafficMode. Enforces green min/max, yellow and all-red clearance, pedestrian walk and

---
 rtl/traffic_pkg.sv | 46 ++++
 rtl/phase_timer.sv | 27 ++
 rtl/traffic_phase_sequencer.sv | 166 ++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared mode, phase, lane and rotation definitions for the intersection
package traffic_pkg;

    localparam logic [1:0] MODE_NIGHT = 2'b00;
    localparam logic [1:0] MODE_DAY   = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    typedef enum logic [2:0] {
        PH_ALLRED = 3'd0,
        PH_GREEN  = 3'd1,
        PH_YELLOW = 3'd2,
        PH_WALK   = 3'd3,
        PH_EMG    = 3'd4
    } phase_t;

    localparam int LANE_N1 = 7;
    localparam int LANE_N2 = 6;
    localparam int LANE_E1 = 5;
    localparam int LANE_E2 = 4;
    localparam int LANE_S1 = 3;
    localparam int LANE_S2 = 2;
    localparam int LANE_W1 = 1;
    localparam int LANE_W2 = 0;

    localparam logic [7:0] ROT_N = (8'b1 << LANE_N1) | (8'b1 << LANE_N2);
    localparam logic [7:0] ROT_E = (8'b1 << LANE_E1) | (8'b1 << LANE_E2);
    localparam logic [7:0] ROT_S = (8'b1 << LANE_S1) | (8'b1 << LANE_S2);
    localparam logic [7:0] ROT_W = (8'b1 << LANE_W1) | (8'b1 << LANE_W2);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Lane pair served by the night rotation for a given direction pointer.
    function automatic logic [7:0] rot_set(input logic [1:0] dir);
        case (dir)
            DIR_N:   rot_set = ROT_N;
            DIR_E:   rot_set = ROT_E;
            DIR_S:   rot_set = ROT_S;
            default: rot_set = ROT_W;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable saturating down counter timing each phase
module phase_timer #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - light phase FSM with green min/max, clearance, walk and preemption
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [7:0] lane_req,
    input  logic [7:0] emg_lanes,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic [7:0] red,
    output logic       walk,
    output logic [2:0] phase,
    output logic       grant_chg
);

    localparam int TW = $clog2(GREEN_MAX);

    localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] T_GREEN  = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_WALK   = TW'(WALK_T - 1);
    localparam logic [TW:0]   GMAX_W   = (TW+1)'(GREEN_MAX);
    localparam logic [TW:0]   GMIN_W   = (TW+1)'(GREEN_MIN);

    phase_t        state, state_n;
    logic [7:0]    cur, cur_n;
    logic          ped_pend, ped_n;
    logic [1:0]    night_ptr, ptr_n;
    logic [7:0]    green_n, yellow_n;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic [TW-1:0] timer_count;
    logic          timer_done;
    logic [TW:0]   elapsed;
    logic          min_met;

    phase_timer #(
        .W         (TW),
        .RESET_VAL (T_ALLRED)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .done     (timer_done)
    );

    // Green cycles completed including the current one.
    assign elapsed = GMAX_W - {1'b0, timer_count};
    assign min_met = (elapsed >= GMIN_W);

    // Phase register plus all Moore output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PH_ALLRED;
            cur       <= 8'h00;
            ped_pend  <= 1'b0;
            night_ptr <= DIR_N;
            green     <= 8'h00;
            yellow    <= 8'h00;
            red       <= 8'hFF;
            walk      <= 1'b0;
            grant_chg <= 1'b0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            ped_pend  <= ped_n;
            night_ptr <= ptr_n;
            green     <= green_n;
            yellow    <= yellow_n;
            red       <= ~(green_n | yellow_n);
            walk      <= (state_n == PH_WALK);
            grant_chg <= (state_n == PH_GREEN) && (state != PH_GREEN);
        end
    end

    // Next phase, active set, pedestrian latch and rotation pointer.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        ptr_n   = night_ptr;
        ped_n   = ped_pend | (mode == MODE_PED);
        case (state)
            PH_ALLRED: begin
                if (timer_done) begin
                    if (mode == MODE_EMG) begin
                        state_n = PH_EMG;
                        cur_n   = emg_lanes;
                    end else if (ped_pend) begin
                        state_n = PH_WALK;
                        ped_n   = 1'b0;
                    end else begin
                        state_n = PH_GREEN;
                        if ((mode == MODE_DAY || mode == MODE_PED) && lane_req != 8'h00) begin
                            cur_n = lane_req;
                        end else begin
                            cur_n = rot_set(night_ptr);
                            ptr_n = night_ptr + 2'd1;
                        end
                    end
                end
            end
            PH_GREEN: begin
                if (mode == MODE_EMG ||
                    (min_met && ped_pend) ||
                    (min_met && mode == MODE_DAY && lane_req != 8'h00 && lane_req != cur) ||
                    timer_done) begin
                    state_n = PH_YELLOW;
                end
            end
            PH_YELLOW: begin
                if (timer_done) begin
                    state_n = PH_ALLRED;
                end
            end
            PH_WALK: begin
                if (mode == MODE_EMG || timer_done) begin
                    state_n = PH_ALLRED;
                end
            end
            PH_EMG: begin
                if (mode != MODE_EMG) begin
                    state_n = PH_YELLOW;
                end else begin
                    cur_n = emg_lanes;
                end
            end
            default: begin
                state_n = PH_ALLRED;
            end
        endcase
    end

    // Lamp sets and timer reload for the phase being entered.
    always_comb begin
        green_n    = 8'h00;
        yellow_n   = 8'h00;
        timer_load = (state_n != state);
        timer_val  = T_ALLRED;
        if (state_n == PH_GREEN || state_n == PH_EMG) begin
            green_n = cur_n;
        end
        if (state_n == PH_YELLOW) begin
            yellow_n = cur_n;
        end
        case (state_n)
            PH_GREEN:  timer_val = T_GREEN;
            PH_YELLOW: timer_val = T_YELLOW;
            PH_WALK:   timer_val = T_WALK;
            PH_EMG:    timer_val = '0;
            default:   timer_val = T_ALLRED;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - directed and randomized checks of the phase sequencer
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b01;
    logic [7:0] lane_req = 8'h00;
    logic [7:0] emg_lanes = 8'h00;
    logic [7:0] green, yellow, red;
    logic       walk, grant_chg;
    logic [2:0] phase;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .lane_req  (lane_req),
        .emg_lanes (emg_lanes),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .walk      (walk),
        .phase     (phase),
        .grant_chg (grant_chg)
    );

    always #5 clk = ~clk;

    // Reference model: phase name, cycles spent in it, active set, pending walk, rotation index.
    int         m_ph;
    int         m_age;
    int         m_nph;
    logic [7:0] m_cur;
    bit         m_ped;
    bit         m_ped_next;
    int         m_ptr;
    bit         m_valid = 0;
    logic [7:0] rot [4] = '{8'hC0, 8'h30, 8'h0C, 8'h03};

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_age = 1; m_cur = 8'h00; m_ped = 0; m_ptr = 0; m_valid = 1;
        end else if (m_valid) begin
            m_nph = m_ph;
            m_ped_next = m_ped || (mode == 2'b10);
            case (m_ph)
                0: if (m_age >= 1) begin
                    if (mode == 2'b11) begin
                        m_nph = 4; m_cur = emg_lanes;
                    end else if (m_ped) begin
                        m_nph = 3; m_ped_next = 0;
                    end else begin
                        m_nph = 1;
                        if ((mode == 2'b01 || mode == 2'b10) && lane_req != 0) m_cur = lane_req;
                        else begin
                            m_cur = rot[m_ptr];
                            m_ptr = (m_ptr + 1) % 4;
                        end
                    end
                end
                1: if (mode == 2'b11 || m_age >= 16 ||
                       (m_age >= 4 && (m_ped || (mode == 2'b01 && lane_req != 0 && lane_req != m_cur))))
                    m_nph = 2;
                2: if (m_age >= 2) m_nph = 0;
                3: if (mode == 2'b11 || m_age >= 6) m_nph = 0;
                default: if (mode != 2'b11) m_nph = 2; else m_cur = emg_lanes;
            endcase
            m_ped = m_ped_next;
            m_age = (m_nph != m_ph) ? 1 : m_age + 1;
            m_ph  = m_nph;
        end
    end

    // Per-cycle comparison of every output against the model, plus lamp safety rules.
    logic [7:0] e_g, e_y;
    always @(negedge clk) begin
        if (m_valid) begin
            e_g = (m_ph == 1 || m_ph == 4) ? m_cur : 8'h00;
            e_y = (m_ph == 2) ? m_cur : 8'h00;
            n_cmp++;
            if ({green, yellow, red, walk, phase, grant_chg} !==
                {e_g, e_y, ~(e_g | e_y), (m_ph == 3), 3'(m_ph), (m_ph == 1 && m_age == 1)}) begin
                n_bad++;
                $display("FAIL model t=%0t got g=%h y=%h r=%h w=%b ph=%0d gc=%b exp g=%h y=%h r=%h w=%b ph=%0d gc=%b",
                         $time, green, yellow, red, walk, phase, grant_chg,
                         e_g, e_y, ~(e_g | e_y), (m_ph == 3), m_ph, (m_ph == 1 && m_age == 1));
            end
            n_cmp++;
            if ((green & yellow) != 0 || red !== ~(green | yellow) || (walk && (green | yellow) != 0)) begin
                n_bad++;
                $display("FAIL invariant t=%0t got g=%h y=%h r=%h w=%b exp disjoint/complement/walk-clear",
                         $time, green, yellow, red, walk);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [7:0] lr);
        rst = 1'b1; mode = m; lane_req = lr; emg_lanes = 8'h00;
        step(); step();
        chk("reset_red", red, 8'hFF);
        chk("reset_green", green, 8'h00);
        chk("reset_phase", phase, 0);
        rst = 1'b0;
    endtask

    logic [7:0] lr_tab [6] = '{8'h00, 8'hC0, 8'h30, 8'h0C, 8'h03, 8'hF0};

    initial begin
        // Day request, then a lane change after the minimum green.
        do_reset(2'b01, 8'hC0);
        step(); chk("t1_green", green, 8'hC0); chk("t1_grant", grant_chg, 1);
        step(); chk("t1_grant_once", grant_chg, 0);
        step(); lane_req = 8'h30;
        step(); chk("t2_hold_c3", green, 8'hC0);
        step(); chk("t2_yel0", yellow, 8'hC0);
        step(); chk("t2_yel1", yellow, 8'hC0);
        step(); chk("t2_allred", red, 8'hFF);
        step(); chk("t2_green30", green, 8'h30); chk("t2_grant", grant_chg, 1);

        // Night rotation with fixed-length greens.
        do_reset(2'b00, 8'h00);
        for (int k = 1; k <= 95; k++) begin
            step();
            if ((k - 1) % 19 == 0)  chk("t3_start", green, rot[((k - 1) / 19) % 4]);
            if ((k - 1) % 19 == 15) chk("t3_last", green, rot[((k - 1) / 19) % 4]);
            if ((k - 1) % 19 == 16) chk("t3_yel", yellow, rot[((k - 1) / 19) % 4]);
            if ((k - 1) % 19 == 18) chk("t3_allred", red, 8'hFF);
        end

        // Pedestrian pulse during green.
        do_reset(2'b01, 8'hC0);
        step(); step(); mode = 2'b10;
        step(); mode = 2'b01;
        step(); chk("t4_green3", green, 8'hC0);
        step(); chk("t4_yel", yellow, 8'hC0);
        step(); step(); chk("t4_allred", red, 8'hFF);
        for (int k = 0; k < 6; k++) begin
            step(); chk("t4_walk", walk, 1);
        end
        step(); chk("t4_walk_end", walk, 0);
        step(); chk("t4_regreen", green, 8'hC0);

        // Emergency from green cycle 0.
        do_reset(2'b01, 8'hC0);
        step(); mode = 2'b11; emg_lanes = 8'h0C;
        step(); chk("t5_yel", yellow, 8'hC0);
        step(); step(); chk("t5_allred", red, 8'hFF);
        step(); chk("t5_emg", green, 8'h0C); chk("t5_phase", phase, 4);
        emg_lanes = 8'h03;
        step(); chk("t5_emg2", green, 8'h03);
        mode = 2'b01;
        step(); chk("t5_exit_yel", yellow, 8'h03);

        // Emergency aborting walk, then reset inside emergency.
        do_reset(2'b01, 8'hC0);
        step(); mode = 2'b10;
        step(); mode = 2'b01;
        for (int k = 0; k < 7; k++) step();
        chk("t6_walk", walk, 1);
        mode = 2'b11; emg_lanes = 8'h0C;
        step(); chk("t6_abort", walk, 0); chk("t6_abort_red", red, 8'hFF);
        step(); chk("t6_emg", green, 8'h0C);
        rst = 1'b1;
        step(); chk("t6_rst_red", red, 8'hFF); chk("t6_rst_phase", phase, 0);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(11) == 0) begin
                case ($urandom_range(9))
                    0, 1, 2: mode = 2'b00;
                    3, 4, 5, 6: mode = 2'b01;
                    7, 8: mode = 2'b10;
                    default: mode = 2'b11;
                endcase
            end
            if ($urandom_range(7) == 0) lane_req = lr_tab[$urandom_range(5)];
            if ($urandom_range(5) == 0) emg_lanes = 8'($urandom);
            rst = ($urandom_range(399) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
